novram_ctrl: RTL

NOVRAM_CTRL -- requirements
Module: novram_ctrl

---
 rtl/novram_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/novram_ctrl.sv
// rtl/novram_ctrl.sv - NOVRAM controller: CPU-visible working RAM with a nonvolatile shadow image
// Store copies working->shadow, recall copies shadow->working, one nibble per cycle.
module novram_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CSn,
    input  logic              WEn,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    input  logic              STORE,
    input  logic              RECALLn,
    output logic              BUSY
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STORE_RUN  = 2'd1,
        RECALL_RUN = 2'd2
    } state_t;

    logic [DATA_W-1:0] working_mem [DEPTH];
    logic [DATA_W-1:0] shadow_mem  [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              store_r_q, store_r_d, store_p_q, store_p_d;
    logic              recall_r_q, recall_r_d, recall_p_q, recall_p_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic              store_rise, recall_fall;
    logic              wk_we, sh_we;
    logic [ADDR_W-1:0] wk_addr;
    logic [DATA_W-1:0] wk_data;

    always_comb begin
        store_r_d   = STORE;
        store_p_d   = store_r_q;
        recall_r_d  = RECALLn;
        recall_p_d  = recall_r_q;
        store_rise  = store_r_q & ~store_p_q;
        recall_fall = ~recall_r_q & recall_p_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        wk_we   = 1'b0;
        sh_we   = 1'b0;
        wk_addr = A;
        wk_data = DIN;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Recall wins a same-cycle tie; the store edge is simply dropped.
                if (recall_fall) begin
                    state_d = RECALL_RUN;
                end else if (store_rise) begin
                    state_d = STORE_RUN;
                end
                wk_we = ~CSn & ~WEn;
            end
            STORE_RUN: begin
                sh_we = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
            RECALL_RUN: begin
                wk_we   = 1'b1;
                wk_addr = cnt_q;
                wk_data = shadow_mem[cnt_q];
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Keyed off the next state so DOUT flips to all ones on the same edge BUSY rises.
        dout_d = (state_d == IDLE) ? working_mem[A] : '1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= RECALL_RUN;
            cnt_q      <= '0;
            store_r_q  <= 1'b0;
            store_p_q  <= 1'b0;
            recall_r_q <= 1'b1;
            recall_p_q <= 1'b1;
            dout_q     <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            store_r_q  <= store_r_d;
            store_p_q  <= store_p_d;
            recall_r_q <= recall_r_d;
            recall_p_q <= recall_p_d;
            dout_q     <= dout_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge CLK) begin
        if (wk_we) begin
            working_mem[wk_addr] <= wk_data;
        end
        if (sh_we) begin
            shadow_mem[cnt_q] <= working_mem[cnt_q];
        end
    end

    assign BUSY = (state_q != IDLE);
    assign DOUT = dout_q;

endmodule
